debug_unit_ctrl: RTL and testbench
==================================

// Module: debug_unit_ctrl
// PURPOSE
//  Host-side controller for the MIPS pipeline debug interface.
//  - Decodes single-byte commands from a UART receiver.
//  - Loads program words into instruction memory through the dunit write port.
//  - Sequences pipeline execution through the dunit clock enable: continuous run or single step.
//  - Reports the current PC back through a UART transmitter handshake.
// PARAMETERS
//  NB_REG    32    data/addr width of the dunit memory bus and PC
//  NB_BYTE   8     UART byte width
//  NB_WIDHT  9     instruction memory byte-address width (2^9 = 512 B, 128 words)
//  CMD_LOAD  8'h4C ('L') load program
//  CMD_RUN   8'h43 ('C') run continuously until halt
//  CMD_STEP  8'h53 ('S') execute one clock
// PORTS
//  i_clk             in   1        system clock
//  i_reset           in   1        reset, asynchronous, active-high
//  i_rx_data         in   NB_BYTE  received byte, valid when i_rx_valid=1
//  i_rx_valid        in   1        one-cycle pulse per received byte
//  i_tx_done         in   1        one-cycle pulse: transmitter finished the current byte
//  i_halt            in   1        level; pipeline has retired HALT (all-ones) instruction
//  i_pc              in   NB_REG   current PC from IF stage
//  o_tx_data         out  NB_BYTE  byte to transmit, stable from o_tx_start until i_tx_done
//  o_tx_start        out  1        one-cycle pulse: start transmitting o_tx_data
//  o_dunit_clk_en    out  1        pipeline clock enable (registered)
//  o_dunit_w_en      out  1        one-cycle instruction memory write strobe
//  o_dunit_mem_addr  out  NB_REG   instruction memory byte address
//  o_dunit_mem_data  out  NB_REG   instruction word to write
//  o_busy            out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; load address=0; byte counter=0.
//  States: IDLE, LOAD, WRITE, RUN, STEP, SEND, WAIT_TX.
//  IDLE:
//   - i_rx_valid with CMD_LOAD -> LOAD; address cleared to 0.
//   - CMD_RUN -> RUN.
//   - CMD_STEP -> STEP.
//   - any other byte -> queue reply 8'h3F, go SEND.
//  LOAD: bytes are assembled MSB first into a 32-bit shift register.
//   - On the 4th byte (byte t) -> WRITE.
//   - At t+1: o_dunit_w_en=1 for exactly one cycle, with addr=current address and data=assembled word.
//  WRITE:
//   - address += 4.
//   - If word==32'hFFFF_FFFF: reply 8'h4B ('K'), go SEND.
//   - Else if the write used the last word address (2^NB_WIDHT-4): reply 8'hEE, go SEND; address wraps to 0.
//   - Else return to LOAD.
//  o_dunit_clk_en is held 0 in IDLE, LOAD, WRITE, SEND and WAIT_TX.
//  RUN:
//   - o_dunit_clk_en=1 starting the cycle after entry.
//   - The first cycle i_halt=1 is sampled, o_dunit_clk_en=0 on the next edge and the state goes to SEND_PC.
//   - If i_halt is already 1 on entry, no enable cycle is issued.
//  STEP: exactly one cycle of o_dunit_clk_en=1, regardless of i_halt, then SEND_PC.
//  SEND_PC: queues the 4 PC bytes, MSB first, captured at the same edge the enable drops.
//  SEND / WAIT_TX:
//   - Per byte: o_tx_data loaded together with a one-cycle o_tx_start, then wait for i_tx_done.
//   - After the last byte, return to IDLE.
//  i_rx_valid outside IDLE/LOAD is ignored (dropped, no reply).
//  Simultaneous i_halt and entry into RUN: treated as already halted.
//  i_tx_done outside WAIT_TX is ignored.
//  Reset mid-operation:
//   - Immediate return to reset values; a partial word is discarded, no w_en.
//   - A clk_en pulse in flight is truncated.
// TESTING
//  1. Reset mid-LOAD after 2 bytes -> outputs 0, IDLE; a new 'L'+4 bytes writes at addr 0.
//  2. 'L',00,00,00,01, 12,34,56,78, FF,FF,FF,FF -> three w_en pulses:
//     addr 0/4/8, data 1/0x12345678/0xFFFFFFFF; then tx 0x4B; clk_en stays 0.
//  3. 'S' with i_pc=0x0000_0010 -> exactly one clk_en cycle; tx 00,00,00,10 each gated by i_tx_done.
//  4. 'C', i_halt raised 7 cycles after clk_en rises -> clk_en high exactly 7 cycles; tx the 4 PC bytes.
//  5. 'C' with i_halt already 1 -> zero clk_en cycles; PC bytes sent.
//     Byte 0x99 in IDLE -> tx 0x3F.
//  6. Load 128 non-halt words -> last write at addr 0x1FC, tx 0xEE, address wraps to 0.
//     rx bytes during RUN are ignored.

Source files
------------

// File: rtl/debug_unit_ctrl.sv
// Host-side debug controller for the MIPS pipeline: decodes UART commands, loads
// instruction memory, gates the pipeline clock (run/step) and reports the PC.
module debug_unit_ctrl #(
  parameter int                 NB_REG   = 32,
  parameter int                 NB_BYTE  = 8,
  parameter int                 NB_WIDHT = 9,
  parameter logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C,
  parameter logic [NB_BYTE-1:0] CMD_RUN  = 8'h43,
  parameter logic [NB_BYTE-1:0] CMD_STEP = 8'h53
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [NB_REG-1:0]  i_pc,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_w_en,
  output logic [NB_REG-1:0]  o_dunit_mem_addr,
  output logic [NB_REG-1:0]  o_dunit_mem_data,
  output logic               o_busy
);

  localparam int NB_BYTES = NB_REG / NB_BYTE;
  localparam int NB_CNT   = $clog2(NB_BYTES);

  localparam logic [NB_CNT-1:0]   LAST_BYTE   = NB_CNT'(NB_BYTES - 1);
  localparam logic [NB_CNT:0]     WORD_BYTES  = (NB_CNT + 1)'(NB_BYTES);
  localparam logic [NB_WIDHT-1:0] LAST_ADDR   = {{(NB_WIDHT-2){1'b1}}, 2'b00};
  localparam logic [NB_WIDHT-1:0] ADDR_STEP   = {{(NB_WIDHT-3){1'b0}}, 3'b100};
  localparam logic [NB_BYTE-1:0]  REPLY_BAD   = NB_BYTE'(8'h3F);
  localparam logic [NB_BYTE-1:0]  REPLY_OK    = NB_BYTE'(8'h4B);
  localparam logic [NB_BYTE-1:0]  REPLY_FULL  = NB_BYTE'(8'hEE);
  localparam logic [NB_REG-1:0]   HALT_WORD   = '1;

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RUN, STEP, SEND_PC, SEND, WAIT_TX
  } state_t;

  state_t              state_q,   state_d;
  logic [NB_WIDHT-1:0] addr_q,    addr_d;
  logic [NB_REG-1:0]   word_q,    word_d;
  logic [NB_CNT-1:0]   byteCnt_q, byteCnt_d;
  logic [NB_REG-1:0]   txBuf_q,   txBuf_d;
  logic [NB_CNT:0]     txCnt_q,   txCnt_d;
  logic [NB_BYTE-1:0]  txData_q,  txData_d;
  logic                txStart_q, txStart_d;
  logic                clkEn_q,   clkEn_d;
  logic                wEn_q,     wEn_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      byteCnt_q <= '0;
      txBuf_q   <= '0;
      txCnt_q   <= '0;
      txData_q  <= '0;
      txStart_q <= 1'b0;
      clkEn_q   <= 1'b0;
      wEn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      byteCnt_q <= byteCnt_d;
      txBuf_q   <= txBuf_d;
      txCnt_q   <= txCnt_d;
      txData_q  <= txData_d;
      txStart_q <= txStart_d;
      clkEn_q   <= clkEn_d;
      wEn_q     <= wEn_d;
    end
  end

  // Strobes (tx start, write enable, clock enable) default low so each is a
  // registered pulse that only lasts while the FSM explicitly requests it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    byteCnt_d = byteCnt_q;
    txBuf_d   = txBuf_q;
    txCnt_d   = txCnt_q;
    txData_d  = txData_q;
    txStart_d = 1'b0;
    clkEn_d   = 1'b0;
    wEn_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d   = LOAD;
            addr_d    = '0;
            byteCnt_d = '0;
          end else if (i_rx_data == CMD_RUN) begin
            state_d = RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_d = STEP;
            clkEn_d = 1'b1;
          end else begin
            txBuf_d = {REPLY_BAD, {(NB_REG-NB_BYTE){1'b0}}};
            txCnt_d = (NB_CNT + 1)'(1);
            state_d = SEND;
          end
        end
      end

      LOAD: begin
        if (i_rx_valid) begin
          word_d    = {word_q[NB_REG-NB_BYTE-1:0], i_rx_data};
          byteCnt_d = byteCnt_q + 1'b1;
          if (byteCnt_q == LAST_BYTE) begin
            byteCnt_d = '0;
            wEn_d     = 1'b1;
            state_d   = WRITE;
          end
        end
      end

      WRITE: begin
        addr_d = addr_q + ADDR_STEP;
        if (word_q == HALT_WORD) begin
          txBuf_d = {REPLY_OK, {(NB_REG-NB_BYTE){1'b0}}};
          txCnt_d = (NB_CNT + 1)'(1);
          state_d = SEND;
        end else if (addr_q == LAST_ADDR) begin
          txBuf_d = {REPLY_FULL, {(NB_REG-NB_BYTE){1'b0}}};
          txCnt_d = (NB_CNT + 1)'(1);
          state_d = SEND;
        end else begin
          state_d = LOAD;
        end
      end

      // Halt is checked before enabling, so a halt seen on entry costs no clock.
      RUN: begin
        if (i_halt) begin
          txBuf_d = i_pc;
          txCnt_d = WORD_BYTES;
          state_d = SEND_PC;
        end else begin
          clkEn_d = 1'b1;
        end
      end

      STEP: begin
        txBuf_d = i_pc;
        txCnt_d = WORD_BYTES;
        state_d = SEND_PC;
      end

      SEND_PC: state_d = SEND;

      SEND: begin
        txData_d  = txBuf_q[NB_REG-1 -: NB_BYTE];
        txStart_d = 1'b1;
        txBuf_d   = txBuf_q << NB_BYTE;
        txCnt_d   = txCnt_q - 1'b1;
        state_d   = WAIT_TX;
      end

      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = (txCnt_q == '0) ? IDLE : SEND;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_tx_data        = txData_q;
  assign o_tx_start       = txStart_q;
  assign o_dunit_clk_en   = clkEn_q;
  assign o_dunit_w_en     = wEn_q;
  assign o_dunit_mem_addr = {{(NB_REG-NB_WIDHT){1'b0}}, addr_q};
  assign o_dunit_mem_data = word_q;
  assign o_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Self-checking bench for debug_unit_ctrl: command table, multi-cycle corner
// sequences and randomized operations against a transaction-level model.
module tb_debug_unit_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        txDone;
  logic        halt;
  logic [31:0] pc;
  logic [7:0]  txData;
  logic        txStart;
  logic        clkEn;
  logic        wEn;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        busy;

  debug_unit_ctrl dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_rx_data       (rxData),
    .i_rx_valid      (rxValid),
    .i_tx_done       (txDone),
    .i_halt          (halt),
    .i_pc            (pc),
    .o_tx_data       (txData),
    .o_tx_start      (txStart),
    .o_dunit_clk_en  (clkEn),
    .o_dunit_w_en    (wEn),
    .o_dunit_mem_addr(memAddr),
    .o_dunit_mem_data(memData),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  // Observed events, appended only by the monitor; the bench compares from a base index.
  wr_t        wrQ[$];
  logic [7:0] txQ[$];
  int         clkEnCycles = 0;

  wr_t        expWr[$];
  logic [7:0] expTx[$];
  int         expAddr = 0;
  int         wrBase = 0;
  int         txBase = 0;
  int         clkBase = 0;

  int checks = 0;
  int errors = 0;

  logic [31:0] loadWords[$];

  initial begin
    forever begin
      @(negedge clk);
      if (wEn) wrQ.push_back('{addr: memAddr, data: memData});
      if (txStart) txQ.push_back(txData);
      if (clkEn) clkEnCycles++;
    end
  end

  // Remote transmitter: finishes each byte 1-3 cycles after its start pulse.
  initial begin
    txDone = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearObs();
    wrBase  = wrQ.size();
    txBase  = txQ.size();
    clkBase = clkEnCycles;
    expWr.delete();
    expTx.delete();
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) expTx.push_back(w[8*k +: 8]);
  endtask

  task automatic checkOutput(input int expClkEn);
    int nWr = wrQ.size() - wrBase;
    int nTx = txQ.size() - txBase;
    check("write count", nWr, expWr.size());
    for (int i = 0; i < nWr && i < expWr.size(); i++) begin
      check("write addr", wrQ[wrBase+i].addr, expWr[i].addr);
      check("write data", wrQ[wrBase+i].data, expWr[i].data);
    end
    check("tx count", nTx, expTx.size());
    for (int i = 0; i < nTx && i < expTx.size(); i++) begin
      check("tx byte", txQ[txBase+i], expTx[i]);
    end
    check("clk_en cycles", clkEnCycles - clkBase, expClkEn);
    check("busy after op", busy, 1'b0);
    check("mem addr after op", memAddr, expAddr);
    clearObs();
  endtask

  task automatic checkResetState();
    check("reset tx_data", txData, 8'h00);
    check("reset tx_start", txStart, 1'b0);
    check("reset clk_en", clkEn, 1'b0);
    check("reset w_en", wEn, 1'b0);
    check("reset mem_addr", memAddr, 32'h0);
    check("reset mem_data", memData, 32'h0);
    check("reset busy", busy, 1'b0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetState();
    @(negedge clk);
    reset = 1'b0;
    expAddr = 0;
    clearObs();
  endtask

  // Model of a load: words land at consecutive byte addresses from 0 until a
  // halt word is written (reply 'K') or the 512-byte memory fills (reply 0xEE).
  task automatic applyLoad();
    int prev;
    sendByte(8'h4C);
    expAddr = 0;
    foreach (loadWords[i]) begin
      for (int k = 3; k >= 0; k--) sendByte(loadWords[i][8*k +: 8]);
      expWr.push_back('{addr: 32'(expAddr), data: loadWords[i]});
      prev    = expAddr;
      expAddr = (expAddr + 4) % 512;
      if (loadWords[i] == 32'hFFFF_FFFF) begin
        expTx.push_back(8'h4B);
        break;
      end
      if (prev == 508) begin
        expTx.push_back(8'hEE);
        break;
      end
    end
    waitIdle();
    checkOutput(0);
  endtask

  // Holds halt low for n enabled cycles (n >= 5); stray rx bytes are sent mid-run.
  task automatic applyRun(input int n, input logic [31:0] pcVal);
    int waitCnt = 0;
    pc   = pcVal;
    halt = 1'b0;
    sendByte(8'h43);
    while (!clkEn && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    check("run clk_en rise", clkEn, 1'b1);
    sendByte(8'h4C);
    sendByte(8'h99);
    repeat (n - 5) @(negedge clk);
    halt = 1'b1;
    waitIdle();
    halt = 1'b0;
    pushWord(pcVal);
    checkOutput(n);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pcVal;
    logic        haltVal;
    int          expClkEn;
    int          expTxLen;
    logic [31:0] expTxWord;
  } vec_t;

  task automatic applyStimulus(input vec_t v);
    pc   = v.pcVal;
    halt = v.haltVal;
    sendByte(v.cmd);
    waitIdle();
    halt = 1'b0;
    for (int k = v.expTxLen - 1; k >= 0; k--) expTx.push_back(v.expTxWord[8*k +: 8]);
    checkOutput(v.expClkEn);
  endtask

  initial begin
    vec_t vecs[7];
    logic [7:0] b;
    logic [31:0] w;

    vecs[0] = '{8'h99, 32'h0000_0000, 1'b0, 0, 1, 32'h0000_003F};
    vecs[1] = '{8'h00, 32'h0000_0000, 1'b0, 0, 1, 32'h0000_003F};
    vecs[2] = '{8'h53, 32'h0000_0010, 1'b0, 1, 4, 32'h0000_0010};
    vecs[3] = '{8'h53, 32'hDEAD_BEEF, 1'b1, 1, 4, 32'hDEAD_BEEF};
    vecs[4] = '{8'h43, 32'h0000_ABCD, 1'b1, 0, 4, 32'h0000_ABCD};
    vecs[5] = '{8'h63, 32'h0000_0000, 1'b0, 0, 1, 32'h0000_003F};
    vecs[6] = '{8'h4B, 32'h0000_0000, 1'b0, 0, 1, 32'h0000_003F};

    reset   = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    halt    = 1'b0;
    pc      = 32'h0;
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b0;
    clearObs();

    // Reset in the middle of a word; the next load must start byte-aligned at 0.
    sendByte(8'h4C);
    sendByte(8'h12);
    sendByte(8'h34);
    pulseReset();
    check("no write after reset", wrQ.size() - wrBase, 0);
    loadWords = '{32'hCAFE_F00D, 32'hFFFF_FFFF};
    applyLoad();

    loadWords = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};
    applyLoad();

    foreach (vecs[i]) applyStimulus(vecs[i]);

    applyRun(7, 32'h0000_0124);

    loadWords.delete();
    for (int i = 0; i < 128; i++) loadWords.push_back($urandom() & 32'h7FFF_FFFF);
    applyLoad();

    // Reset while the pipeline is enabled must cut the enable immediately.
    pc = 32'h0;
    sendByte(8'h43);
    repeat (3) @(negedge clk);
    check("clk_en before reset", clkEn, 1'b1);
    pulseReset();

    for (int iter = 0; iter < 24; iter++) begin
      case ($urandom_range(0, 3))
        0: begin
          do b = 8'($urandom()); while (b == 8'h4C || b == 8'h43 || b == 8'h53);
          sendByte(b);
          waitIdle();
          expTx.push_back(8'h3F);
          checkOutput(0);
        end
        1: begin
          w    = $urandom();
          pc   = w;
          halt = 1'($urandom_range(0, 1));
          sendByte(8'h53);
          waitIdle();
          halt = 1'b0;
          pushWord(w);
          checkOutput(1);
        end
        2: applyRun($urandom_range(5, 14), $urandom());
        default: begin
          loadWords.delete();
          for (int i = $urandom_range(0, 4); i > 0; i--) loadWords.push_back($urandom());
          loadWords.push_back(32'hFFFF_FFFF);
          applyLoad();
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
